// File: rtl/iob_cache_be_arbiter.sv
`default_nettype none
// ============================================================================
// iob_cache_be_arbiter: round-robin sharing of one back-end native port by two
// cache back-ends, one transaction at a time.
// Revision: 1.0
// ============================================================================
module iob_cache_be_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ack,
  input  logic                m1_req,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ack,
  output logic                s_req,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_ack,
  output logic                grant,
  output logic                busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t r_state;
  logic   r_grant;
  logic   r_prio;

  logic                w_busy;
  logic                w_sel_req;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [DATA_W/8-1:0] w_sel_wstrb;

  // prio only moves on completion, so a master that keeps req high after its
  // ack yields to a waiting peer in the following IDLE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (m0_req || m1_req) begin
            r_grant <= (m0_req && m1_req) ? r_prio : m1_req;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (s_ack) begin
            r_prio  <= ~r_grant;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign w_busy      = (r_state == BUSY);
  assign w_sel_req   = r_grant ? m1_req   : m0_req;
  assign w_sel_addr  = r_grant ? m1_addr  : m0_addr;
  assign w_sel_wdata = r_grant ? m1_wdata : m0_wdata;
  assign w_sel_wstrb = r_grant ? m1_wstrb : m0_wstrb;

  // Back-end bus is forced to zero outside a transaction.
  assign s_req   = w_busy & w_sel_req;
  assign s_addr  = w_busy ? w_sel_addr  : '0;
  assign s_wdata = w_busy ? w_sel_wdata : '0;
  assign s_wstrb = w_busy ? w_sel_wstrb : '0;

  // Completion is gated by BUSY so a late or repeated s_ack in IDLE is dropped.
  assign m0_ack   = w_busy & s_ack & ~r_grant;
  assign m1_ack   = w_busy & s_ack &  r_grant;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

  assign grant = r_grant;
  assign busy  = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_iob_cache_be_arbiter.sv
`default_nettype none
// ============================================================================
// tb_iob_cache_be_arbiter: randomized and directed bench with a RAM slave,
// a transaction-level round-robin reference model and per-master scoreboards.
// Revision: 1.0
// ============================================================================
module tb_iob_cache_be_arbiter;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    m_req;
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  logic [SW-1:0] m_wstrb [2];
  logic [DW-1:0] m_rdata [2];
  logic [1:0]    m_ack;
  logic          s_req, s_ack, grant, busy;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [SW-1:0] s_wstrb;

  iob_cache_be_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m_req[0]), .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]),
    .m0_rdata(m_rdata[0]), .m0_ack(m_ack[0]),
    .m1_req(m_req[1]), .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]),
    .m1_rdata(m_rdata[1]), .m1_ack(m_ack[1]),
    .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ack(s_ack), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] ram     [64];
  logic [DW-1:0] ref_mem [64];
  txn_t q0[$];
  txn_t q1[$];
  int   grant_log[$];

  int            lat_fixed = -1;
  bit            dup_mode  = 1'b0;
  bit   [1:0]    auto_en   = 2'b00;
  bit   [1:0]    cont      = 2'b00;
  bit   [1:0]    got_ack   = 2'b00;
  int            ack_cnt [2] = '{0, 0};
  int            issue_cnt = 0;
  logic [DW-1:0] last_rdata [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic issue(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s);
    txn_t t;
    t.a = a; t.d = d; t.s = s;
    m_addr[i] = a; m_wdata[i] = d; m_wstrb[i] = s; m_req[i] = 1'b1;
    issue_cnt++;
    if (i == 0) q0.push_back(t);
    else        q1.push_back(t);
  endtask

  task automatic issue_rand(input int i);
    logic [AW-1:0] a;
    logic [SW-1:0] s;
    a = '0;
    a[7:2] = 6'($urandom_range(0, 63));
    s = ($urandom_range(0, 1) == 1) ? SW'($urandom_range(1, 15)) : '0;
    issue(i, a, $urandom, s);
  endtask

  task automatic clear_masters();
    m_req = 2'b00; got_ack = 2'b00;
    q0.delete(); q1.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1; clear_masters();
    @(posedge clk); #3;
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    auto_en = 2'b00; cont = 2'b00;
    for (int k = 0; k < 300 && !(m_req == 2'b00 && !busy); k++) @(negedge clk);
    chk("drain", (m_req == 2'b00 && !busy), 1);
  endtask

  // RAM slave: random or fixed latency, optional duplicate ack.
  initial begin : slave
    int sl_wait, dup_left, idx;
    s_ack = 1'b0; s_rdata = '0; sl_wait = -1; dup_left = 0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        s_ack = 1'b0; sl_wait = -1; dup_left = 0;
      end else if (s_ack && dup_left > 0) begin
        dup_left--;
      end else begin
        s_ack = 1'b0; s_rdata = $urandom;
        if (!s_req) sl_wait = -1;
        else begin
          if (sl_wait < 0) sl_wait = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 2));
          if (sl_wait == 0) begin
            idx = int'(s_addr[7:2]);
            for (int b = 0; b < SW; b++)
              if (s_wstrb[b]) ram[idx][8*b +: 8] = s_wdata[8*b +: 8];
            s_rdata = ram[idx]; s_ack = 1'b1; sl_wait = -1;
            dup_left = dup_mode ? 1 : 0;
          end else sl_wait--;
        end
      end
    end
  end

  // Master driver: drop or renew after ack, optionally issue random requests.
  initial begin : driver
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        for (int i = 0; i < 2; i++) begin
          if (m_req[i] && got_ack[i]) begin
            got_ack[i] = 1'b0;
            if (cont[i]) issue_rand(i);
            else m_req[i] = 1'b0;
          end else if (!m_req[i] && auto_en[i] && $urandom_range(0, 2) == 0) begin
            issue_rand(i);
          end
        end
      end
    end
  end

  // Monitor: transaction-level round-robin model plus per-master scoreboards.
  initial begin : monitor
    int owner, rr, idx;
    txn_t t;
    owner = -1; rr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        owner = -1; rr = 0;
        chk("rst_busy", busy, 0);
        chk("rst_s_req", s_req, 0);
        chk("rst_acks", m_ack, 0);
        chk("rst_grant", grant, 0);
      end else begin
        chk("busy", busy, owner >= 0);
        if (owner >= 0) begin
          chk("grant", grant, owner);
          chk("s_req", s_req, m_req[owner]);
          chk("s_addr", s_addr, m_addr[owner]);
          chk("s_wdata", s_wdata, m_wdata[owner]);
          chk("s_wstrb", s_wstrb, m_wstrb[owner]);
        end else begin
          chk("idle_s_req", s_req, 0);
          chk("idle_s_bus", {s_addr, s_wstrb}, 0);
          chk("idle_s_wdata", s_wdata, 0);
        end
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("m%0d_ack", i), m_ack[i], (owner == i) && s_ack);
          chk($sformatf("m%0d_rdata_pass", i), m_rdata[i], s_rdata);
          if (m_ack[i]) begin
            if ((i == 0 ? q0.size() : q1.size()) == 0) begin
              tests++; fails++;
              $display("FAIL sb_empty: m%0d_ack with no outstanding request at %0t", i, $time);
            end else begin
              if (i == 0) t = q0.pop_front();
              else        t = q1.pop_front();
              idx = int'(t.a[7:2]);
              chk("txn_addr", s_addr, t.a);
              chk("txn_wstrb", s_wstrb, t.s);
              if (t.s == '0) chk("txn_rdata", m_rdata[i], ref_mem[idx]);
              else begin
                chk("txn_wdata", s_wdata, t.d);
                for (int b = 0; b < SW; b++)
                  if (t.s[b]) ref_mem[idx][8*b +: 8] = t.d[8*b +: 8];
              end
            end
            last_rdata[i] = m_rdata[i];
            ack_cnt[i]++;
            got_ack[i] = 1'b1;
            grant_log.push_back(i);
          end
        end
        if (owner >= 0) begin
          if (s_ack) begin rr = 1 - owner; owner = -1; end
        end else if (m_req != 2'b00) begin
          owner = (m_req == 2'b11) ? rr : (m_req[1] ? 1 : 0);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : main
    int c;
    for (int k = 0; k < 64; k++) begin
      ram[k] = 32'hA5A50000 + DW'(k);
      ref_mem[k] = ram[k];
    end
    rst = 1'b1; m_req = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0; m_wdata[i] = '0; m_wstrb[i] = '0; last_rdata[i] = '0;
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Single read, slave acks one cycle after s_req.
    lat_fixed = 1;
    @(posedge clk); #1;
    issue(0, 24'h10, 32'h0, 4'h0);
    @(negedge clk); chk("sr_s_req_c0", s_req, 0);
    @(negedge clk); chk("sr_s_req_c1", s_req, 1); chk("sr_s_addr", s_addr, 24'h10);
    @(negedge clk);
    chk("sr_m0_ack", m_ack[0], 1);
    chk("sr_m0_rdata", m_rdata[0], s_rdata);
    chk("sr_rdata_val", m_rdata[0], 32'hA5A50004);
    chk("sr_m1_ack", m_ack[1], 0);
    wait_idle();

    // Simultaneous requests after reset: strict alternation starting at m0.
    do_reset();
    lat_fixed = -1;
    grant_log.delete();
    @(posedge clk); #1;
    issue_rand(0); issue_rand(1); cont = 2'b11;
    for (int k = 0; k < 200 && grant_log.size() < 4; k++) @(negedge clk);
    cont = 2'b00;
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr_seq%0d", k), (k < grant_log.size()) ? grant_log[k] : -1, k % 2);
    wait_idle();

    // Write pass-through, then read it back through the other master.
    @(posedge clk); #1;
    issue(1, 24'h20, 32'hDEADBEEF, 4'hF);
    for (int k = 0; k < 20 && !busy; k++) @(negedge clk);
    chk("wr_grant", grant, 1);
    chk("wr_s_wdata", s_wdata, 32'hDEADBEEF);
    chk("wr_s_wstrb", s_wstrb, 4'hF);
    wait_idle();
    c = ack_cnt[0];
    @(posedge clk); #1;
    issue(0, 24'h20, 32'h0, 4'h0);
    for (int k = 0; k < 20 && ack_cnt[0] == c; k++) @(negedge clk);
    chk("rd_back", last_rdata[0], 32'hDEADBEEF);
    wait_idle();

    // Duplicate acks from the slave must not create extra completions.
    dup_mode = 1'b1;
    c = issue_cnt - ack_cnt[0] - ack_cnt[1];
    auto_en = 2'b11;
    repeat (60) @(posedge clk);
    wait_idle();
    dup_mode = 1'b0;
    chk("dup_ack_count", issue_cnt - ack_cnt[0] - ack_cnt[1], c);

    // Reset while m1 owns the back-end.
    lat_fixed = 6;
    c = ack_cnt[1];
    @(posedge clk); #1;
    issue(1, 24'h40, 32'h12345678, 4'h3);
    for (int k = 0; k < 20 && !(busy && grant); k++) @(negedge clk);
    chk("rm_busy_g1", busy && grant, 1);
    #2 rst = 1'b1;
    clear_masters();
    #1;
    chk("rm_s_req", s_req, 0);
    chk("rm_busy", busy, 0);
    chk("rm_m1_ack", m_ack[1], 0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0; lat_fixed = -1;
    chk("rm_no_ack", ack_cnt[1], c);
    grant_log.delete();
    @(posedge clk); #1;
    issue_rand(0); issue_rand(1);
    for (int k = 0; k < 50 && grant_log.size() < 2; k++) @(negedge clk);
    chk("rm_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    chk("rm_second", (grant_log.size() > 1) ? grant_log[1] : -1, 1);
    wait_idle();

    // Randomized traffic with varying persistence and duplicate acks.
    auto_en = 2'b11;
    for (int r = 0; r < 400; r++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 19) == 0) cont = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) dup_mode = ~dup_mode;
    end
    wait_idle();
    dup_mode = 1'b0;
    chk("rand_all_acked", q0.size() + q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/iob_cache_be_arbiter.md
IOB_CACHE_BE_ARBITER -- requirements
Module: iob_cache_be_arbiter

Interface
REQ-001 The block SHALL have parameters, one per line:
- ADDR_W, default 24, back-end byte address width.
- DATA_W, default 32, back-end data width.
REQ-002 The block SHALL have ports, one per line, with clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 request, native level.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_wstrb  in  DATA_W/8  master 0 byte strobes; 0 means read.
- m0_rdata  out  DATA_W  master 0 read data.
- m0_ack  out  1  master 0 completion pulse.
- m1_req / m1_addr / m1_wdata / m1_wstrb / m1_rdata / m1_ack  same as m0, for master 1.
- s_req  out  1  shared back-end request.
- s_addr  out  ADDR_W  shared back-end address.
- s_wdata  out  DATA_W  shared back-end write data.
- s_wstrb  out  DATA_W/8  shared back-end strobes.
- s_rdata  in  DATA_W  shared back-end read data.
- s_ack  in  1  shared back-end completion.
- grant  out  1  index of the master currently owning the back-end; valid when busy=1.
- busy  out  1  a transaction is in flight.

Function
REQ-003 The block SHALL share one back-end native memory port between two cache back-ends, one transaction at a time.
REQ-004 Masters SHALL hold req, addr, wdata and wstrb stable from assertion until the cycle their ack is 1.
REQ-005 The slave SHALL assert s_ack for at least one cycle per transaction; s_ack seen in IDLE SHALL be ignored.
REQ-006 The FSM SHALL have two states, IDLE and BUSY; reset state is IDLE.
REQ-007 In IDLE with no req:
- stay in IDLE;
- s_req=0, busy=0.
REQ-008 In IDLE with exactly one req set, the block SHALL register grant to that master and enter BUSY on the next edge.
REQ-009 In IDLE with both reqs set:
- grant the master selected by a 1-bit round-robin pointer prio;
- prio=0 selects m0, prio=1 selects m1.
REQ-010 In BUSY, the block SHALL drive:
- s_req = req of the granted master;
- s_addr, s_wdata, s_wstrb = the granted master's signals;
- busy=1.
REQ-011 In BUSY, the non-granted master's ack SHALL be 0; its request SHALL remain pending and SHALL not be dropped.
REQ-012 In BUSY with s_ack=1, the block SHALL:
- drive ack of the granted master to 1 combinationally that cycle;
- drive its rdata = s_rdata combinationally that cycle;
- set prio to the non-granted master's index;
- return to IDLE on the next edge.
REQ-013 In IDLE, s_addr, s_wdata and s_wstrb SHALL be 0 and s_req SHALL be 0.
REQ-014 Both m_rdata outputs SHALL be s_rdata when not acked (don't care for masters), and both m_ack SHALL be 0 except as given in REQ-012.
REQ-015 Latency from req to s_req SHALL be 1 cycle (IDLE to BUSY); from s_ack to the next grant SHALL be 1 cycle (IDLE re-arbitration).
REQ-016 A master that keeps req high after its ack SHALL be treated as a new request in the following IDLE cycle, subject to round-robin.
REQ-017 Under continuous requests from both masters, grants SHALL strictly alternate; no master SHALL wait more than one foreign transaction.
REQ-018 If the granted master drops req in BUSY (protocol violation), s_req SHALL follow it to 0; the FSM SHALL stay in BUSY until s_ack.

Reset
REQ-019 On rst=1, regardless of clock, the block SHALL set:
- state=IDLE, grant=0, prio=0, busy=0;
- s_req=0, m0_ack=0, m1_ack=0.
REQ-020 Reset asserted mid-transaction SHALL abort the in-flight transaction with no ack to any master; post-reset arbitration restarts from prio=0.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single read: m0_req=1, addr=0x10, wstrb=0; slave acks 1 cycle after s_req -> s_req at cycle +1, s_addr=0x10, m0_ack=1 with m0_rdata=s_rdata, m1_ack=0.
- Simultaneous requests after reset: m0 and m1 both request -> m0 served first; m1 granted in the IDLE cycle after m0_ack; grant sequence 0,1,0,1 over four back-to-back transactions.
- Write pass-through: m1 writes addr=0x20, wdata=0xDEADBEEF, wstrb=0xF -> s_wdata=0xDEADBEEF, s_wstrb=0xF; later m0 read of 0x20 returns 0xDEADBEEF from the single-port RAM model.
- Late duplicate ack: RAM model acks two consecutive cycles -> second ack, arriving in IDLE, produces no m_ack pulse.
- Reset mid-transaction: assert rst while BUSY with grant=1 -> s_req=0, busy=0, no m1_ack; next dual request is granted to m0.
